alu_result_fifo: RTL and testbench
==================================

Name: alu_result_fifo

Overview:
Downstream stage of the synchronous arithmetic unit. It captures each registered result word and its 4-bit status vector when they are flagged valid, and buffers them in a first-word-fall-through FIFO with a valid/ready output handshake. It also keeps run-time statistics for the consumer: a saturating error counter, an OR-accumulated sticky status, and a sticky drop flag.

Parameters:
BITS, 32, width of the result word; must equal the arithmetic unit's BITS.
DEPTH, 8, number of FIFO entries; power of two, at least 2.
CNT_W, 16, width of the saturating error counter.

Ports:
i_clk  input  1  clock; all state changes on its rising edge.
i_reset  input  1  asynchronous, active-high reset.
i_valid  input  1  i_result/i_status hold a new result this cycle (issue valid delayed by one cycle).
i_result  input  BITS  signed result word from the arithmetic unit.
i_status  input  4  status {ERROR, NOT_EVEN_ZERO, ZEROS, OVERFLOW}.
i_ready  input  1  consumer accepts the head entry this cycle.
i_clear  input  1  synchronous clear of the statistics (o_err_cnt, o_sticky_status, o_drop).
o_valid  output  1  FIFO not empty; head entry presented.
o_data  output  BITS  head result word.
o_data_status  output  4  head status vector.
o_count  output  $clog2(DEPTH)+1  number of stored entries.
o_full  output  1  count == DEPTH.
o_empty  output  1  count == 0.
o_err_cnt  output  CNT_W  number of accepted entries with status ERROR=1; saturating.
o_sticky_status  output  4  bitwise OR of the statuses of all accepted entries since the last reset or clear.
o_drop  output  1  sticky: an input was discarded because the FIFO was full.

Behaviour:
- Reset (asynchronous, i_reset=1): write/read pointers=0; o_count=0; o_empty=1; o_full=0; o_valid=0; o_data=0; o_data_status=0; o_err_cnt=0; o_sticky_status=0; o_drop=0. Storage contents are don't-care.
- A reset asserted mid-stream discards all stored entries. The first i_valid after release is written to slot 0.
- push = i_valid && (!o_full || pop). pop = o_valid && i_ready.
- Push writes {i_status, i_result} at the write pointer, and the pointer increments modulo DEPTH. Pop increments the read pointer modulo DEPTH.
- o_count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: data pushed into an empty FIFO appears on o_valid/o_data on the next cycle. There is no same-cycle bypass.
- FWFT: o_data/o_data_status show the entry at the read pointer combinationally from storage. Both are driven 0 when empty.
- Full with simultaneous pop: the push is accepted and the count stays at DEPTH.
- Empty with i_ready=1: no pop occurs and no state changes.
- Full, i_valid=1, no pop: the input is discarded, o_drop is set on the next edge, and all other state is unchanged.
- Statistics update only on an accepted push:
  - if i_status[3]=1, o_err_cnt increments, holding at 2^CNT_W-1;
  - o_sticky_status |= i_status.
  - A discarded input does not update statistics.
- i_clear=1: o_err_cnt, o_sticky_status and o_drop are set to 0 on the next edge.
  - Clear has priority: a same-cycle push or drop does not contribute to the statistics.
  - FIFO contents and pointers are unaffected by i_clear.
- Occupancy FSM, derived from count: EMPTY -> ACTIVE on a push-only cycle.
  - ACTIVE -> FULL when count reaches DEPTH.
  - ACTIVE -> EMPTY when count reaches 0.
  - FULL -> ACTIVE on a pop-only cycle.
  - No direct EMPTY<->FULL transition except when DEPTH=1, which is disallowed.

Decomposition:
- Package alu_pkg holds:
  - typedef status_t (logic [3:0]);
  - index constants ST_ERROR=3, ST_NOT_EVEN_ZERO=2, ST_ZEROS=1, ST_OVERFLOW=0;
  - typedef fifo_entry_t, a packed struct {status_t status; logic signed [BITS-1:0] result}. The struct is sized by the BITS package constant.
- One sub-module: sat_counter (parameter W; inputs inc and clr; output cnt), instantiated for o_err_cnt.

Test Plan:
- Reset then idle: all outputs are 0, o_empty=1, o_valid=0.
- Push 3 entries (results 0x00000005, 0xFFFFFFFF, 0x00000000; statuses 4'b0100, 4'b0000, 4'b0010), then hold i_ready=1 -> the same three results come out in order, one per cycle. The first appears 1 cycle after its push; o_sticky_status=4'b0110 and o_count returns to 0.
- Push 8 entries with i_ready=0 -> o_full=1. A 9th push with value 0x0000AAAA -> o_drop=1, o_count=8, and the dropped word is never output.
- While full, push and pop in the same cycle -> count stays 8, the head advances, and the new entry becomes the last one read.
- Push 5 entries with status 4'b1000 -> o_err_cnt=5. Then assert i_clear in the same cycle as a 6th error push -> o_err_cnt=0 and o_sticky_status=0, while the 6th entry is still stored.
- With CNT_W=2, push 5 error entries -> o_err_cnt saturates at 3. Then assert i_reset with 4 entries stored -> o_count=0 and o_valid=0 immediately (asynchronous reset).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the arithmetic unit's result path.
// The status vector layout must match the producer's {ERROR, NOT_EVEN_ZERO, ZEROS, OVERFLOW} ordering.
package alu_pkg;

  localparam int BITS = 32;

  typedef logic [3:0] status_t;

  localparam int ST_ERROR         = 3;
  localparam int ST_NOT_EVEN_ZERO = 2;
  localparam int ST_ZEROS         = 1;
  localparam int ST_OVERFLOW      = 0;

  typedef struct packed {
    status_t                status;
    logic signed [BITS-1:0] result;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ACTIVE,
    OCC_FULL
  } occ_state_t;

endpackage

// File: rtl/alu_result_fifo_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through result FIFO with valid/ready output and consumer statistics
// (saturating error count, OR-accumulated status, sticky overflow-drop flag).
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int BITS  = alu_pkg::BITS,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [BITS-1:0]          i_result,
  input  logic [3:0]               i_status,
  input  logic                     i_ready,
  input  logic                     i_clear,
  output logic                     o_valid,
  output logic [BITS-1:0]          o_data,
  output logic [3:0]               o_data_status,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [CNT_W-1:0]         o_err_cnt,
  output logic [3:0]               o_sticky_status,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BITS+3:0] mem_q [DEPTH];
  logic [BITS+3:0] head;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  status_t         sticky_q, sticky_d;
  logic            drop_q, drop_d;
  occ_state_t      state_q, state_d;
  logic            push, pop, discard;

  assign o_valid = (state_q != OCC_EMPTY);
  assign o_full  = (state_q == OCC_FULL);
  assign o_empty = (state_q == OCC_EMPTY);

  assign pop     = o_valid && i_ready;
  assign push    = i_valid && (!o_full || pop);
  assign discard = i_valid && !push;

  // Storage is intentionally left out of reset so it can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_status, i_result};
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign o_data        = o_valid ? head[BITS-1:0] : '0;
  assign o_data_status = o_valid ? head[BITS+3:BITS] : '0;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY:  if (push && !pop) state_d = OCC_ACTIVE;
      OCC_ACTIVE: begin
        if (count_d == CW'(DEPTH))  state_d = OCC_FULL;
        else if (count_d == '0)     state_d = OCC_EMPTY;
      end
      OCC_FULL:   if (pop && !push) state_d = OCC_ACTIVE;
      default:    state_d = OCC_EMPTY;
    endcase
  end

  // Clear overrides any same-cycle contribution from a push or a discard.
  always_comb begin
    sticky_d = sticky_q;
    drop_d   = drop_q;
    if (i_clear) begin
      sticky_d = '0;
      drop_d   = 1'b0;
    end else begin
      if (push)    sticky_d = sticky_q | i_status;
      if (discard) drop_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= OCC_EMPTY;
      sticky_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      state_q  <= state_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (i_clk),
    .rst (i_reset),
    .inc (push && i_status[ST_ERROR]),
    .clr (i_clear),
    .cnt (o_err_cnt)
  );

  assign o_count         = count_q;
  assign o_sticky_status = sticky_q;
  assign o_drop          = drop_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench: table-driven vectors plus hand sequences, with a scoreboard queue
// of expected FIFO entries and a small statistics model. A CNT_W=2 instance checks saturation.
module tb_alu_result_fifo;

  logic        i_clk, i_reset, i_valid, i_ready, i_clear;
  logic [31:0] i_result;
  logic [3:0]  i_status;

  logic        o_valid, o_full, o_empty, o_drop;
  logic [31:0] o_data;
  logic [3:0]  o_data_status, o_sticky_status;
  logic [3:0]  o_count;
  logic [15:0] o_err_cnt;

  logic        s_valid, s_full, s_empty, s_drop;
  logic [31:0] s_data;
  logic [3:0]  s_data_status, s_sticky_status;
  logic [3:0]  s_count;
  logic [1:0]  s_err_cnt;

  alu_result_fifo #(.BITS(32), .DEPTH(8), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_result(i_result),
    .i_status(i_status), .i_ready(i_ready), .i_clear(i_clear),
    .o_valid(o_valid), .o_data(o_data), .o_data_status(o_data_status),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_err_cnt(o_err_cnt),
    .o_sticky_status(o_sticky_status), .o_drop(o_drop)
  );

  alu_result_fifo #(.BITS(32), .DEPTH(8), .CNT_W(2)) dut_s (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_result(i_result),
    .i_status(i_status), .i_ready(i_ready), .i_clear(i_clear),
    .o_valid(s_valid), .o_data(s_data), .o_data_status(s_data_status),
    .o_count(s_count), .o_full(s_full), .o_empty(s_empty), .o_err_cnt(s_err_cnt),
    .o_sticky_status(s_sticky_status), .o_drop(s_drop)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] res;
  } ent_t;

  typedef struct packed {
    logic        v;
    logic [31:0] r;
    logic [3:0]  s;
    logic        rdy;
    logic        clr;
    logic [3:0]  exp_count;
  } vec_t;

  ent_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_err;
  logic [1:0]  m_err_s;
  logic [3:0]  m_sticky;
  logic        m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_err = '0; m_err_s = '0; m_sticky = '0; m_drop = 1'b0;
  endtask

  task automatic check_outputs();
    chk("count", 64'(o_count), 64'(sb.size()));
    chk("count_s", 64'(s_count), 64'(sb.size()));
    chk("valid", 64'(o_valid), 64'(sb.size() != 0));
    chk("full", 64'(o_full), 64'(sb.size() == 8));
    chk("empty", 64'(o_empty), 64'(sb.size() == 0));
    if (sb.size() != 0) begin
      chk("data", 64'(o_data), 64'(sb[0].res));
      chk("data_status", 64'(o_data_status), 64'(sb[0].st));
    end else begin
      chk("data_zero", 64'(o_data), 64'd0);
      chk("status_zero", 64'(o_data_status), 64'd0);
    end
    chk("err_cnt", 64'(o_err_cnt), 64'(m_err));
    chk("err_cnt_sat", 64'(s_err_cnt), 64'(m_err_s));
    chk("sticky", 64'(o_sticky_status), 64'(m_sticky));
    chk("drop", 64'(o_drop), 64'(m_drop));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] r, input logic [3:0] s,
                       input logic rdy, input logic clr);
    logic push, pop;
    i_valid = v; i_result = r; i_status = s; i_ready = rdy; i_clear = clr;
    #1;
    check_outputs();
    pop  = (sb.size() != 0) && rdy;
    push = v && ((sb.size() < 8) || pop);
    $display("cyc t=%0t v=%0b res=%h st=%b rdy=%0b clr=%0b push=%0b pop=%0b cnt=%0d out=%h",
             $time, v, r, s, rdy, clr, push, pop, o_count, o_data);
    @(posedge i_clk);
    if (pop) void'(sb.pop_front());
    if (push) sb.push_back({s, r});
    if (clr) begin
      m_err = '0; m_err_s = '0; m_sticky = '0; m_drop = 1'b0;
    end else begin
      if (push) begin
        m_sticky = m_sticky | s;
        if (s[3]) begin
          if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
          if (m_err_s != 2'd3)   m_err_s = m_err_s + 2'd1;
        end
      end
      if (v && !push) m_drop = 1'b1;
    end
    @(negedge i_clk);
  endtask

  vec_t tbl[7];

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_result = '0; i_status = '0; i_ready = 1'b0; i_clear = 1'b0;
    model_reset();

    // Three pushes, then drain with ready held high.
    tbl[0] = '{1'b1, 32'h00000005, 4'b0100, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{1'b1, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, 4'd1};
    tbl[2] = '{1'b1, 32'h00000000, 4'b0010, 1'b0, 1'b0, 4'd2};
    tbl[3] = '{1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 4'd3};
    tbl[4] = '{1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 4'd2};
    tbl[5] = '{1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 4'd1};
    tbl[6] = '{1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 4'd0};

    repeat (2) @(negedge i_clk);
    #1;
    check_outputs();
    i_reset = 1'b0;
    @(negedge i_clk);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    for (int k = 0; k < 7; k++) begin
      chk("tbl_count", 64'(o_count), 64'(tbl[k].exp_count));
      cycle(tbl[k].v, tbl[k].r, tbl[k].s, tbl[k].rdy, tbl[k].clr);
    end
    chk("sticky_0110", 64'(o_sticky_status), 64'h6);

    // Fill to full, then a discarded push.
    for (int k = 0; k < 8; k++) cycle(1'b1, 32'h100 + 32'(k), 4'b0000, 1'b0, 1'b0);
    chk("full_flag", 64'(o_full), 64'd1);
    cycle(1'b1, 32'h0000AAAA, 4'b0001, 1'b0, 1'b0);
    chk("drop_set", 64'(o_drop), 64'd1);
    chk("count_8", 64'(o_count), 64'd8);

    // Full with simultaneous push and pop.
    cycle(1'b1, 32'h0000BBBB, 4'b0001, 1'b1, 1'b0);
    chk("count_stays_8", 64'(o_count), 64'd8);
    for (int k = 0; k < 9; k++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Error counting, saturation on the narrow instance, and clear priority.
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b1, 32'hE0 + 32'(k), 4'b1000, 1'b0, 1'b0);
    chk("err_5", 64'(o_err_cnt), 64'd5);
    chk("err_sat_3", 64'(s_err_cnt), 64'd3);
    cycle(1'b1, 32'hE5, 4'b1000, 1'b0, 1'b1);
    chk("err_cleared", 64'(o_err_cnt), 64'd0);
    chk("count_6", 64'(o_count), 64'd6);

    // Asynchronous reset mid-stream with 4 entries stored.
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("count_4", 64'(o_count), 64'd4);
    #2;
    i_reset = 1'b1;
    #1;
    chk("async_count", 64'(o_count), 64'd0);
    chk("async_valid", 64'(o_valid), 64'd0);
    model_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    cycle(1'b1, 32'h12345678, 4'b0001, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
